pipe_bundle_buf: RTL
====================

Name: pipe_bundle_buf

Overview:
- Parametrised inter-stage register for the multi-issue core. It replaces the hand-written per-stage always blocks, which were driven by a global write-enable.
- Carries a bundle of LANES slots. Each lane has its own valid bit and a DATA_W payload.
- Uses a ready/valid handshake with a one-entry skid register, so the upstream ready path is fully registered.
- Supports global flush, per-lane kill (squash of younger lanes after a taken branch), and a saturating stall counter.
- One instance sits between each pair of stages (F2/DEC, DEC/ISS, ISS/EX, ...).

Parameters:
- LANES, 2, number of issue lanes per bundle.
- DATA_W, 64, payload bits per lane (inst + ctrl + pc, packed by the caller).
- CNT_W, 16, width of the stall counter.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  LANES  per-lane valid of the incoming bundle.
- in_data_i  in  LANES*DATA_W  incoming payload; lane k occupies bits [k*DATA_W +: DATA_W].
- in_ready_o  out  1  buffer can accept a bundle this cycle (registered).
- out_valid_o  out  LANES  per-lane valid of the head bundle.
- out_data_o  out  LANES*DATA_W  head bundle payload.
- out_ready_i  in  1  downstream consumes the head bundle.
- flush_i  in  1  discard everything held, plus any bundle presented this cycle.
- kill_i  in  LANES  clear the valid bit of the selected lanes in the head bundle.
- stall_cnt_o  out  CNT_W  cycles the head was valid but not consumed (saturating).

Behaviour:
- Reset: all valid bits 0, payload registers 0, state EMPTY, in_ready_o=1, stall_cnt_o=0. Reset acts immediately, including mid-transfer.
- Bundle terms:
  - in_fire = in_ready_o && |in_valid_i
  - out_fire = out_ready_i && |out_valid_o
  - An all-zero valid vector is not a bundle and is never stored.
- Storage: head register (drives out_*) and skid register. States are EMPTY, HEAD (head only), FULL (head + skid).
- Transitions when flush_i=0:
  - EMPTY: in_fire -> HEAD; input loads the head.
  - HEAD, in_fire && out_fire: stay HEAD; input loads the head.
  - HEAD, in_fire && !out_fire: -> FULL; input loads the skid.
  - HEAD, !in_fire && out_fire: -> EMPTY.
  - FULL, out_fire: -> HEAD; skid moves to head. in_ready_o is 0 in FULL, so no input is taken.
- in_ready_o is registered. It equals 1 in EMPTY/HEAD, 0 in FULL, and 1 on the cycle after a flush.
- Latency: a bundle accepted into an EMPTY buffer appears on out_* the next cycle. Sustained throughput is one bundle per clock with out_ready_i=1.
- Kill:
  - Applied to the head register only; the skid is untouched. Bits are cleared at the clock edge.
  - If kill clears every remaining valid bit in the head, the head counts as consumed:
    - FULL -> HEAD (skid promotes), otherwise -> EMPTY.
    - A simultaneous in_fire is handled exactly as for out_fire.
  - Kill on a cycle with out_fire is a no-op; the head leaves anyway.
  - Kill has no effect when the buffer is EMPTY.
- Flush:
  - Highest priority: overrides kill, in_fire and out_fire.
  - All valid bits clear and state becomes EMPTY. A bundle presented that cycle is dropped.
  - Payload contents are don't-care and are not cleared.
- Priority order: reset > flush > kill > normal transfer.
- Stall counter: increments by 1 in each cycle where |out_valid_o && !out_ready_i && !flush_i. It holds at 2^CNT_W-1 and clears only on reset.
- Payload registers load only on a load event; there is no enable toggling when idle.
- Out-of-range behaviour: none. All widths are exact and kill_i bits beyond the valid lanes have no effect.

Decomposition:
- Shared package/defs: STATE_EMPTY/STATE_HEAD/STATE_FULL encodings (2 bits) and default LANES/DATA_W constants.
- The existing CTRL_BUS/RD_ENC defines remain with the caller, which packs them into DATA_W.
- One natural sub-module: sat_counter (parametrised CNT_W, inc_i, saturating), reused by later perf counters.

Test Plan:
1. Reset, then EMPTY. Present in_valid_i=2'b11 with data A, out_ready_i=1 -> next cycle out_valid_o=2'b11, out_data_o=A, in_ready_o=1. Throughput of 4 back-to-back bundles is 4 cycles.
2. Backpressure: out_ready_i=0, send A then B -> A held on out, B in skid, in_ready_o=0. C is not accepted. Raise out_ready_i -> B on out the next cycle, then C accepted. stall_cnt_o counts the stalled cycles exactly (e.g. 3).
3. Kill: head A valid 2'b11, kill_i=2'b10 -> out_valid_o=2'b01. With the state FULL, kill_i=2'b01 on that head (whose remaining valid is 2'b01) -> head removed and skid B promoted next cycle.
4. Flush in FULL with in_valid_i=2'b11 presented -> next cycle out_valid_o=0, in_ready_o=1, the presented bundle is dropped, and stall_cnt_o does not increment that cycle.
5. Drive reset_ni low asynchronously between clock edges while FULL -> out_valid_o=0 and stall_cnt_o=0 immediately. After release, normal acceptance resumes.
6. Hold out_ready_i=0 with a valid head for 2^CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt_o saturates at 15 and holds.

Source files
------------

// File: rtl/pipe_bundle_buf_pkg.sv
// Shared definitions for the inter-stage bundle buffer.
// State encodings and default bundle geometry.
package pipe_bundle_buf_pkg;

    typedef enum logic [1:0] {
        STATE_EMPTY = 2'd0,
        STATE_HEAD  = 2'd1,
        STATE_FULL  = 2'd2
    } state_e;

    localparam int LANES_DEF  = 2;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_bundle_buf_sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign count_o = r_cnt;

endmodule

// File: rtl/pipe_bundle_buf.sv
// Inter-stage bundle register with one-entry skid, flush,
// per-lane kill and a saturating stall counter.
module pipe_bundle_buf
    import pipe_bundle_buf_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic [LANES-1:0]        in_valid_i,
    input  logic [LANES*DATA_W-1:0] in_data_i,
    output logic                    in_ready_o,
    output logic [LANES-1:0]        out_valid_o,
    output logic [LANES*DATA_W-1:0] out_data_o,
    input  logic                    out_ready_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        kill_i,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    state_e                    r_state;
    logic                      r_in_ready;
    logic [LANES-1:0]          r_head_vld;
    logic [LANES*DATA_W-1:0]   r_head_data;
    logic [LANES-1:0]          r_skid_vld;
    logic [LANES*DATA_W-1:0]   r_skid_data;

    logic                      w_in_fire;
    logic                      w_out_fire;
    logic [LANES-1:0]          w_kill_vld;
    logic                      w_consume;
    state_e                    w_state_nxt;
    logic [LANES-1:0]          w_head_vld_nxt;
    logic [LANES-1:0]          w_skid_vld_nxt;
    logic                      w_load_head;
    logic                      w_head_from_skid;
    logic                      w_load_skid;
    logic                      w_stall;

    assign w_in_fire  = r_in_ready && (|in_valid_i);
    assign w_out_fire = out_ready_i && (|r_head_vld);
    assign w_kill_vld = r_head_vld & ~kill_i;
    // A head whose last valid lane is killed leaves as if consumed.
    assign w_consume  = w_out_fire ||
                        ((|r_head_vld) && !(|w_kill_vld));

    always_comb begin
        w_state_nxt      = r_state;
        w_head_vld_nxt   = r_head_vld;
        w_skid_vld_nxt   = r_skid_vld;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            w_state_nxt    = STATE_EMPTY;
            w_head_vld_nxt = '0;
            w_skid_vld_nxt = '0;
        end else begin
            unique case (r_state)
                STATE_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = STATE_HEAD;
                        w_head_vld_nxt = in_valid_i;
                        w_load_head    = 1'b1;
                    end
                end
                STATE_HEAD: begin
                    if (w_consume && w_in_fire) begin
                        w_head_vld_nxt = in_valid_i;
                        w_load_head    = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt    = STATE_FULL;
                        w_head_vld_nxt = w_kill_vld;
                        w_skid_vld_nxt = in_valid_i;
                        w_load_skid    = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt    = STATE_EMPTY;
                        w_head_vld_nxt = '0;
                    end else begin
                        w_head_vld_nxt = w_kill_vld;
                    end
                end
                STATE_FULL: begin
                    if (w_consume) begin
                        w_state_nxt      = STATE_HEAD;
                        w_head_vld_nxt   = r_skid_vld;
                        w_skid_vld_nxt   = '0;
                        w_head_from_skid = 1'b1;
                    end else begin
                        w_head_vld_nxt = w_kill_vld;
                    end
                end
                default: begin
                    w_state_nxt    = STATE_EMPTY;
                    w_head_vld_nxt = '0;
                    w_skid_vld_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= STATE_EMPTY;
            r_in_ready <= 1'b1;
            r_head_vld <= '0;
            r_skid_vld <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != STATE_FULL);
            r_head_vld <= w_head_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_head_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_head) begin
                r_head_data <= in_data_i;
            end else if (w_head_from_skid) begin
                r_head_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data_i;
            end
        end
    end

    assign w_stall = (|r_head_vld) && !out_ready_i && !flush_i;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .inc_i    (w_stall),
        .count_o  (stall_cnt_o)
    );

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_head_vld;
    assign out_data_o  = r_head_data;

endmodule
